// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } det_state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;

  // Cfg_Len must be able to hold the value MAX_LEN itself.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr has priority over inc and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap modes,
// registered match pulse and saturating match count.
import seq_det_pkg::*;

module seq_detector_param #(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Cfg_Load,
  input  logic [MAX_LEN-1:0] Cfg_Pattern,
  input  logic [LEN_W-1:0]   Cfg_Len,
  input  logic               Cfg_Overlap,
  input  logic               In_Valid,
  input  logic               In1,
  output logic               Out1,
  output logic [CNT_W-1:0]   Match_Count,
  output logic               Cfg_Err,
  output logic               Armed
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  det_state_t         state;
  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic               ovl;

  logic               cfg_legal;
  logic               cfg_apply;
  logic [MAX_LEN-1:0] cfg_mask;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic               accept;
  logic               match;

  assign cfg_legal = (Cfg_Len != '0) && (Cfg_Len <= MAX_LEN_V);
  assign cfg_apply = Cfg_Load && cfg_legal;
  // A shift by MAX_LEN clears every bit, so a full-length mask is all ones.
  assign cfg_mask  = ~({MAX_LEN{1'b1}} << Cfg_Len);
  assign mask      = ~({MAX_LEN{1'b1}} << len);

  assign accept    = In_Valid && !Cfg_Load && (state != UNCFG);
  assign hist_next = {history[MAX_LEN-2:0], In1};
  assign fill_next = (fill == len) ? len : fill + 1'b1;
  assign match     = accept && (fill_next == len) && ((hist_next & mask) == pat);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= UNCFG;
      history <= '0;
      pat     <= '0;
      len     <= '0;
      fill    <= '0;
      ovl     <= 1'b0;
      Out1    <= 1'b0;
      Cfg_Err <= 1'b0;
      Armed   <= 1'b0;
    end else begin
      Out1    <= match;
      Cfg_Err <= Cfg_Load && !cfg_legal;
      if (cfg_apply) begin
        pat     <= Cfg_Pattern & cfg_mask;
        len     <= Cfg_Len;
        ovl     <= Cfg_Overlap;
        history <= '0;
        fill    <= '0;
        state   <= FILL;
        Armed   <= 1'b1;
      end else if (accept) begin
        history <= hist_next;
        if (match && !ovl) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill  <= fill_next;
          state <= (fill_next == len) ? RUN : FILL;
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (match),
    .clr (cfg_apply),
    .q   (Match_Count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (default and CNT_W=2 instances).
module tb_seq_detector_param;

  localparam int ML = 8;
  localparam int LW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Cfg_Load = 1'b0;
  logic [ML-1:0] Cfg_Pattern = '0;
  logic [LW-1:0] Cfg_Len = '0;
  logic          Cfg_Overlap = 1'b0;
  logic          In_Valid = 1'b0;
  logic          In1 = 1'b0;

  logic          out1_a, err_a, armed_a;
  logic [15:0]   cnt_a;
  logic          out1_b, err_b, armed_b;
  logic [1:0]    cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  seq_detector_param #(.MAX_LEN(ML), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .Cfg_Load(Cfg_Load), .Cfg_Pattern(Cfg_Pattern),
    .Cfg_Len(Cfg_Len), .Cfg_Overlap(Cfg_Overlap), .In_Valid(In_Valid), .In1(In1),
    .Out1(out1_a), .Match_Count(cnt_a), .Cfg_Err(err_a), .Armed(armed_a)
  );

  seq_detector_param #(.MAX_LEN(ML), .CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .Cfg_Load(Cfg_Load), .Cfg_Pattern(Cfg_Pattern),
    .Cfg_Len(Cfg_Len), .Cfg_Overlap(Cfg_Overlap), .In_Valid(In_Valid), .In1(In1),
    .Out1(out1_b), .Match_Count(cnt_b), .Cfg_Err(err_b), .Armed(armed_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [ML-1:0] p, input logic [LW-1:0] l, input logic o,
                      input int exp_armed, input int exp_err);
    Cfg_Load = 1'b1; Cfg_Pattern = p; Cfg_Len = l; Cfg_Overlap = o;
    tick();
    Cfg_Load = 1'b0;
    check("armed", int'(armed_a), exp_armed);
    check("cfg_err", int'(err_a), exp_err);
  endtask

  task automatic step(input logic v, input logic b);
    In_Valid = v; In1 = b;
    tick();
    In_Valid = 1'b0;
  endtask

  // bits and pulses are listed first-received in the MSB of the n-bit field.
  task automatic send_bits(input string tag, input logic [31:0] bits, input int n,
                           input logic [31:0] pulses);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i]);
      check($sformatf("%s out1[%0d]", tag, i), int'(out1_a), int'(pulses[n-1-i]));
      check($sformatf("%s sat_out1[%0d]", tag, i), int'(out1_b), int'(pulses[n-1-i]));
    end
  endtask

  initial begin
    tick(); tick();
    RST = 1'b0;
    check("rst out1", int'(out1_a), 0);
    check("rst count", int'(cnt_a), 0);
    check("rst armed", int'(armed_a), 0);
    check("rst cfg_err", int'(err_a), 0);

    send_bits("uncfg", 32'b11, 2, 32'b00);
    check("uncfg count", int'(cnt_a), 0);
    load(8'h00, 4'd0, 1'b1, 0, 1);
    tick();
    check("cfg_err one cycle", int'(err_a), 0);
    check("still uncfg armed", int'(armed_a), 0);

    load(8'b10, 4'd2, 1'b1, 1, 0);
    check("load clears count", int'(cnt_a), 0);
    send_bits("p10", 32'b110010, 6, 32'b001001);
    check("p10 count", int'(cnt_a), 2);

    load(8'b1011, 4'd4, 1'b1, 1, 0);
    send_bits("p1011 ovl", 32'b1011011, 7, 32'b0001001);
    check("p1011 ovl count", int'(cnt_a), 2);
    load(8'b1011, 4'd4, 1'b0, 1, 0);
    send_bits("p1011 novl", 32'b1011011, 7, 32'b0001000);
    check("p1011 novl count", int'(cnt_a), 1);

    load(8'b111, 4'd3, 1'b1, 1, 0);
    send_bits("p111 ovl", 32'b11111, 5, 32'b00111);
    check("p111 ovl count", int'(cnt_a), 3);
    load(8'b111, 4'd3, 1'b0, 1, 0);
    send_bits("p111 novl", 32'b11111, 5, 32'b00100);
    check("p111 novl count", int'(cnt_a), 1);

    // Gapped stream: only valid bits advance the match.
    load(8'b111, 4'd3, 1'b1, 1, 0);
    step(1'b1, 1'b1); check("gap v1", int'(out1_a), 0);
    step(1'b0, 1'b1); check("gap i1", int'(out1_a), 0);
    step(1'b1, 1'b1); check("gap v2", int'(out1_a), 0);
    step(1'b0, 1'b0); check("gap i2", int'(out1_a), 0);
    step(1'b1, 1'b1); check("gap v3", int'(out1_a), 1);
    step(1'b0, 1'b1); check("gap i3", int'(out1_a), 0);
    step(1'b1, 1'b1); check("gap v4", int'(out1_a), 1);
    check("gap count", int'(cnt_a), 2);

    load(8'b1, 4'd1, 1'b1, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1);
      check($sformatf("len1 out1[%0d]", i), int'(out1_a), 1);
      check($sformatf("sat count[%0d]", i), int'(cnt_b), (i > 3) ? 3 : i);
    end
    check("len1 wide count", int'(cnt_a), 6);
    step(1'b1, 1'b0);
    check("len1 zero bit", int'(out1_a), 0);

    load(8'h00, 4'd0, 1'b1, 1, 1);
    check("rej0 count kept", int'(cnt_a), 6);
    load(8'h00, 4'd9, 1'b0, 1, 1);
    check("rej9 count kept", int'(cnt_a), 6);
    tick();
    check("rej err clears", int'(err_a), 0);
    send_bits("after rej", 32'b1, 1, 32'b1);
    check("after rej count", int'(cnt_a), 7);

    // Config strobe in the same cycle as a valid bit discards the bit.
    In_Valid = 1'b1; In1 = 1'b1;
    load(8'h00, 4'd0, 1'b0, 1, 1);
    In_Valid = 1'b0;
    check("load+valid out1", int'(out1_a), 0);
    check("load+valid count", int'(cnt_a), 7);

    load(8'b1011, 4'd4, 1'b1, 1, 0);
    send_bits("pre rst", 32'b101, 3, 32'b000);
    In_Valid = 1'b1; In1 = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0; In_Valid = 1'b0;
    check("rst drop out1", int'(out1_a), 0);
    check("rst drop count", int'(cnt_a), 0);
    check("rst drop armed", int'(armed_a), 0);
    send_bits("post rst", 32'b1011, 4, 32'b0000);
    check("post rst count", int'(cnt_a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
